pipe_hazard_unit: RTL and testbench

- Parametrised hazard controller for the DPCPU in-order pipeline; supersedes the fixed two-stage STALL unit.
- Keeps an internal scoreboard of in-flight register writers, one slot per post-ID stage (EXE, MEM, WB, …).
- From the scoreboard it produces the load-use stall, the PC/IF-ID write enables and per-operand forwarding selects.
- Sits beside ID_STAGE: takes the decoded fields of the instruction in ID and drives the ID/EXE bubble.

---
 rtl/pipe_hazard_if.sv | 41 ++++
 rtl/pipe_hazard_unit.sv | 114 +++++++++++
 tb/tb_pipe_hazard_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// ============================================================================
// pipe_hazard_if : ID-stage decode fields in, hazard controls out
// Revision 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_if #(
   parameter int AW  = 5,
   parameter int FSW = 3
);
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic          id_wreg;
   logic [AW-1:0] id_rn;
   logic          id_m2reg;
   logic          flush;
   logic          stall;
   logic          pc_we;
   logic          ifid_we;
   logic          idexe_kill;
   logic [FSW-1:0] fwd_a_sel;
   logic [FSW-1:0] fwd_b_sel;
   logic [31:0]   stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wreg, id_rn, id_m2reg, flush,
      input  stall, pc_we, ifid_we, idexe_kill, fwd_a_sel, fwd_b_sel, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_wreg, id_rn, id_m2reg, flush,
      output stall, pc_we, ifid_we, idexe_kill, fwd_a_sel, fwd_b_sel, stall_count
   );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ============================================================================
// pipe_hazard_unit : scoreboard-based load-use stall / forwarding controller
// Optional feature macro: HAZARD_FWD_EN (forwarding selects + ready-by-slot)
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_unit #(
   parameter int AW        = 5,
   parameter int DEPTH     = 3,
   parameter int LOAD_SLOT = 1,
   parameter int FSW       = 3
) (
   input  logic         Clock,
   input  logic         Resetn,
   pipe_hazard_if.slave hz
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] wreg_q, wreg_d;
   logic [DEPTH-1:0] m2reg_q, m2reg_d;
   logic [AW-1:0]    rn_q [DEPTH];
   logic [AW-1:0]    rn_d [DEPTH];
   logic [31:0]      stall_count_q, stall_count_d;

   logic           a_hit, b_hit;
   logic [FSW-1:0] a_slot, b_slot;
   logic           a_ld, b_ld;
   logic           a_rdy, b_rdy;
   logic           stall;
   logic           insert;

   // Descending scan so the youngest (lowest-index) match is the one kept.
   always_comb begin
      a_hit  = 1'b0;
      a_slot = '0;
      a_ld   = 1'b0;
      b_hit  = 1'b0;
      b_slot = '0;
      b_ld   = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (v_q[k] && wreg_q[k] && hz.id_use_rs && (hz.id_rs != '0) && (rn_q[k] == hz.id_rs)) begin
            a_hit  = 1'b1;
            a_slot = FSW'(k);
            a_ld   = m2reg_q[k];
         end
         if (v_q[k] && wreg_q[k] && hz.id_use_rt && (hz.id_rt != '0) && (rn_q[k] == hz.id_rt)) begin
            b_hit  = 1'b1;
            b_slot = FSW'(k);
            b_ld   = m2reg_q[k];
         end
      end
   end

`ifdef HAZARD_FWD_EN
   assign a_rdy        = !a_hit || !a_ld || (a_slot >= FSW'(LOAD_SLOT));
   assign b_rdy        = !b_hit || !b_ld || (b_slot >= FSW'(LOAD_SLOT));
   assign hz.fwd_a_sel = a_hit ? (a_slot + 1'b1) : '0;
   assign hz.fwd_b_sel = b_hit ? (b_slot + 1'b1) : '0;
`else
   // Without forwarding only the write-before-read WB slot is safe to read.
   logic unused_ld;
   assign unused_ld    = a_ld ^ b_ld;
   assign a_rdy        = !a_hit || (a_slot == FSW'(DEPTH - 1));
   assign b_rdy        = !b_hit || (b_slot == FSW'(DEPTH - 1));
   assign hz.fwd_a_sel = '0;
   assign hz.fwd_b_sel = '0;
`endif

   assign stall          = hz.id_valid && !(a_rdy && b_rdy);
   assign insert         = hz.id_valid && !stall && !hz.flush;
   assign hz.stall       = stall;
   assign hz.pc_we       = !stall;
   assign hz.ifid_we     = !stall;
   assign hz.idexe_kill  = stall || hz.flush;
   assign hz.stall_count = stall_count_q;

   always_comb begin
      v_d        = {v_q[DEPTH-2:0], insert};
      wreg_d     = {wreg_q[DEPTH-2:0], insert && hz.id_wreg};
      m2reg_d    = {m2reg_q[DEPTH-2:0], insert && hz.id_m2reg};
      rn_d[0]    = insert ? hz.id_rn : '0;
      for (int k = 1; k < DEPTH; k++) begin
         rn_d[k] = rn_q[k-1];
      end
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         v_q           <= '0;
         wreg_q        <= '0;
         m2reg_q       <= '0;
         stall_count_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            rn_q[k] <= '0;
         end
      end else begin
         v_q           <= v_d;
         wreg_q        <= wreg_d;
         m2reg_q       <= m2reg_d;
         stall_count_q <= stall_count_d;
         for (int k = 0; k < DEPTH; k++) begin
            rn_q[k] <= rn_d[k];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// ============================================================================
// tb_pipe_hazard_unit : scoreboard bench for pipe_hazard_unit (either HAZARD_FWD_EN build)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_unit;
   localparam int AW        = 5;
   localparam int DEPTH     = 3;
   localparam int LOAD_SLOT = 1;
   localparam int FSW       = 3;

`ifdef HAZARD_FWD_EN
   localparam int FWD_ON        = 1;
   localparam int EXP_ALU_STALL = 0;
   localparam int EXP_LD_STALL  = 1;
   localparam int EXP_LD_FWD    = 2;
   localparam int EXP_ALU_FWD   = 1;
`else
   localparam int FWD_ON        = 0;
   localparam int EXP_ALU_STALL = DEPTH - 1;
   localparam int EXP_LD_STALL  = DEPTH - 1;
   localparam int EXP_LD_FWD    = 0;
   localparam int EXP_ALU_FWD   = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_if #(.AW(AW), .FSW(FSW)) hz ();

   pipe_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .FSW(FSW)) dut (
      .Clock  (clk),
      .Resetn (rst_n),
      .hz     (hz)
   );

   typedef struct packed {
      logic           stall;
      logic           kill;
      logic [FSW-1:0] fa;
      logic [FSW-1:0] fb;
      logic [31:0]    cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic          m_v  [DEPTH];
   logic          m_w  [DEPTH];
   logic          m_ld [DEPTH];
   logic [AW-1:0] m_rn [DEPTH];
   logic [31:0]   m_cnt;
   logic          m_stall;

   logic           s_stall, s_kill;
   logic [FSW-1:0] s_fa, s_fb;
   logic [31:0]    s_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: ascending search, first hit is the youngest writer.
   function automatic void model_op(input logic [AW-1:0] a, input logic use_a,
                                    output logic rdy, output logic [FSW-1:0] sel);
      int s;
      s   = -1;
      rdy = 1'b1;
      sel = '0;
      if (use_a && a != '0) begin
         for (int k = 0; k < DEPTH && s < 0; k++)
            if (m_v[k] && m_w[k] && m_rn[k] == a) s = k;
      end
      if (s >= 0) begin
         if (FWD_ON != 0) begin
            sel = FSW'(s + 1);
            rdy = !m_ld[s] || (s >= LOAD_SLOT);
         end else begin
            rdy = (s == DEPTH - 1);
         end
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         m_v[k] = 1'b0; m_w[k] = 1'b0; m_ld[k] = 1'b0; m_rn[k] = '0;
      end
      m_cnt   = '0;
      m_stall = 1'b0;
      exp_q.delete();
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic w,
                        input logic [AW-1:0] rn, input logic ld, input logic fl);
      hz.id_valid  = v;
      hz.id_rs     = rs;
      hz.id_rt     = rt;
      hz.id_use_rs = urs;
      hz.id_use_rt = urt;
      hz.id_wreg   = w;
      hz.id_rn     = rn;
      hz.id_m2reg  = ld;
      hz.flush     = fl;
   endtask

   task automatic sample();
      exp_t e;
      logic ra, rb;
      logic [FSW-1:0] fa, fb;
      model_op(hz.id_rs, hz.id_use_rs, ra, fa);
      model_op(hz.id_rt, hz.id_use_rt, rb, fb);
      e.stall = hz.id_valid && !(ra && rb);
      e.kill  = e.stall || hz.flush;
      e.fa    = fa;
      e.fb    = fb;
      e.cnt   = m_cnt;
      m_stall = e.stall;
      exp_q.push_back(e);

      e = exp_q.pop_front();
      check("stall",   32'(hz.stall),      32'(e.stall));
      check("pc_we",   32'(hz.pc_we),      32'(!e.stall));
      check("ifid_we", 32'(hz.ifid_we),    32'(!e.stall));
      check("kill",    32'(hz.idexe_kill), 32'(e.kill));
      check("fwd_a",   32'(hz.fwd_a_sel),  32'(e.fa));
      check("fwd_b",   32'(hz.fwd_b_sel),  32'(e.fb));
      check("count",   hz.stall_count,     e.cnt);
      s_stall = hz.stall;
      s_kill  = hz.idexe_kill;
      s_fa    = hz.fwd_a_sel;
      s_fb    = hz.fwd_b_sel;
      s_cnt   = hz.stall_count;
   endtask

   task automatic advance();
      for (int k = DEPTH - 1; k > 0; k--) begin
         m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_ld[k] = m_ld[k-1]; m_rn[k] = m_rn[k-1];
      end
      if (hz.id_valid && !m_stall && !hz.flush) begin
         m_v[0] = 1'b1; m_w[0] = hz.id_wreg; m_ld[0] = hz.id_m2reg; m_rn[0] = hz.id_rn;
      end else begin
         m_v[0] = 1'b0; m_w[0] = 1'b0; m_ld[0] = 1'b0; m_rn[0] = '0;
      end
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
   endtask

   task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urs, input logic urt, input logic w,
                       input logic [AW-1:0] rn, input logic ld, input logic fl);
      @(negedge clk);
      drive(v, rs, rt, urs, urt, w, rn, ld, fl);
      #1;
      sample();
      @(posedge clk);
      advance();
   endtask

   task automatic alu(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rn);
      step(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rn, 1'b0, 1'b0);
   endtask

   task automatic lw(input logic [AW-1:0] rs, input logic [AW-1:0] rn);
      step(1'b1, rs, '0, 1'b1, 1'b0, 1'b1, rn, 1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nst;
      int guard;
      logic [31:0] c0;

      model_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      #2;
      check("rst_stall", 32'(hz.stall),       32'd0);
      check("rst_pc_we", 32'(hz.pc_we),       32'd1);
      check("rst_ifid",  32'(hz.ifid_we),     32'd1);
      check("rst_fwd_a", 32'(hz.fwd_a_sel),   32'd0);
      check("rst_fwd_b", 32'(hz.fwd_b_sel),   32'd0);
      check("rst_count", hz.stall_count,      32'd0);
      check("rst_kill0", 32'(hz.idexe_kill),  32'd0);
      hz.flush = 1'b1;
      #1;
      check("rst_kill1", 32'(hz.idexe_kill),  32'd1);
      hz.flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ALU producer then dependent reader of $3
      alu(5'd1, 5'd2, 5'd3);
      nst = 0; guard = 0;
      do begin
         alu(5'd3, 5'd5, 5'd4);
         if (s_stall) nst++;
         guard++;
      end while (s_stall && guard < 8);
      check("alu_stalls", 32'(nst), 32'(EXP_ALU_STALL));
      check("alu_fwd_a", 32'(s_fa), 32'(EXP_ALU_FWD));
`ifdef HAZARD_FWD_EN
      alu(5'd3, 5'd0, 5'd6);
      check("alu_fwd_a2", 32'(s_fa), 32'd2);
      alu(5'd1, 5'd3, 5'd7);
      check("alu_fwd_b3", 32'(s_fb), 32'd3);
`endif
      idle(3);

      // Load-use on both operands
      lw(5'd0, 5'd2);
      c0 = m_cnt;
      nst = 0; guard = 0;
      do begin
         alu(5'd2, 5'd2, 5'd6);
         if (s_stall) nst++;
         guard++;
      end while (s_stall && guard < 8);
      check("lu_stalls", 32'(nst), 32'(EXP_LD_STALL));
      check("lu_fwd_a", 32'(s_fa), 32'(EXP_LD_FWD));
      check("lu_fwd_b", 32'(s_fb), 32'(EXP_LD_FWD));
      check("lu_count", s_cnt, c0 + 32'(EXP_LD_STALL));
      idle(3);

      // Register 0 never matches
      alu(5'd1, 5'd1, 5'd0);
      alu(5'd0, 5'd0, 5'd8);
      check("r0_stall", 32'(s_stall), 32'd0);
      check("r0_fwd_a", 32'(s_fa), 32'd0);
      idle(3);

      // Unused rt ignores a pending load to $7
      lw(5'd0, 5'd7);
      step(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      check("nouse_stall", 32'(s_stall), 32'd0);
      check("nouse_fwd_b", 32'(s_fb), 32'd0);
      idle(3);

      // Flushed instruction leaves a bubble
      step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
      check("flush_kill", 32'(s_kill), 32'd1);
      alu(5'd9, 5'd0, 5'd10);
      check("flush_fwd_a", 32'(s_fa), 32'd0);
      check("flush_stall", 32'(s_stall), 32'd0);
      idle(3);

      // Saturation: preload the counter while a stall is pending
      lw(5'd0, 5'd2);
      @(negedge clk);
      drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      force dut.stall_count_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1;
      sample();
      #1;
      release dut.stall_count_q;
      @(posedge clk);
      advance();
      alu(5'd2, 5'd2, 5'd6);
      check("sat_count", s_cnt, 32'hFFFF_FFFF);
      idle(3);

      // Asynchronous reset in the middle of a load-use stall
      lw(5'd0, 5'd2);
      @(negedge clk);
      drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      #1;
      sample();
      check("pre_rst_stall", 32'(s_stall), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_stall", 32'(hz.stall),     32'd0);
      check("arst_pc_we", 32'(hz.pc_we),     32'd1);
      check("arst_fwd_a", 32'(hz.fwd_a_sel), 32'd0);
      check("arst_fwd_b", 32'(hz.fwd_b_sel), 32'd0);
      check("arst_count", hz.stall_count,    32'd0);
      model_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      alu(5'd2, 5'd2, 5'd6);
      check("post_rst_stall", 32'(s_stall), 32'd0);

      // Random traffic on a small register set
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 9) < 8,
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
